dmem_arbiter: RTL
=================

# dmem_arbiter

Two-lane data-memory arbiter for the dual-issue core: it shares the single-port `Data_Memory` between the two MEM-stage lanes. Each lane's load or store is serialized onto the memory bus. The memory controls are held for a configurable number of cycles, the read data is captured, and completion is signalled back per lane. The block sits between the core's two memory-stage slots and the `mem_address` / `mem_data_in` / `control_memwrite` / `control_memread` / `mem_data_out` bus.

## Interface

**Parameters**
- `MEM_LATENCY`, default 1: cycles each access holds the memory controls; legal range ≥1.

**Ports**
- `CLOCK` in 1: sole clock; rising edge.
- `RESET` in 1: asynchronous, active-low reset.
- `l0_req`, `l1_req` in 1: lane request; held with its operands until granted.
- `l0_we`, `l1_we` in 1: 1 = store, 0 = load.
- `l0_addr`, `l1_addr` in 64: byte address.
- `l0_wdata`, `l1_wdata` in 64: store data.
- `l0_gnt`, `l1_gnt` out 1: combinational grant; transfer occurs on `req & gnt` at the rising edge.
- `l0_done`, `l1_done` out 1: one-cycle completion pulse.
- `l0_rdata`, `l1_rdata` out 64: load data, valid while `done` is high.
- `busy` out 1: high while an access is in flight.
- `mem_address` out 64: to memory.
- `mem_data_in` out 64: to memory.
- `control_memwrite` out 1: to memory.
- `control_memread` out 1: to memory.
- `mem_data_out` in 64: from memory; combinational read data.

## Operation

**FSM**
- States: IDLE, ACCESS.
- Grants are issued only in IDLE:
  - `l0_gnt = IDLE & l0_req & (!l1_req | prio==0)`
  - `l1_gnt = IDLE & l1_req & (!l0_req | prio==1)`
- On a transfer: capture lane id, `we`, `addr`, `wdata`; load `cnt` with `MEM_LATENCY-1`; go to ACCESS.
- `prio` flips to the other lane after every grant, giving round-robin when both lanes keep requesting. `prio` resets to 0, so lane 0 (the older instruction) wins the first conflict.
- In ACCESS:
  - Memory outputs come from the captured registers.
  - `control_memread = !we_q`, `control_memwrite = we_q`, held for all `MEM_LATENCY` cycles.
  - `cnt` decrements each cycle.
  - When `cnt==0`, the edge captures `mem_data_out` into the granted lane's `rdata` (zero for stores), pulses that lane's `done` for one cycle, and returns to IDLE.
- Outside ACCESS, `control_memread` and `control_memwrite` are 0. `mem_address` and `mem_data_in` hold their last values.
- The non-granted lane's `rdata` holds its last value. Its `done` stays 0.
- `busy` = (state == ACCESS).

**Reset**
- Values: state IDLE, `prio` 0, `cnt` 0; all outputs 0, including both `rdata` buses and `mem_address`.
- Reset asserted mid-access aborts the access immediately. Memory controls drop asynchronously and no `done` is issued.

**Boundaries**
- Both lanes request in IDLE: exactly one grant, chosen by `prio`. The loser keeps `req` high and is granted in the next IDLE cycle.
- A lane's `req` is ignored during ACCESS; it sees no grant until IDLE.
- The IDLE cycle that carries a `done` pulse may also issue a new grant, to either lane.
- A `req` that drops before it is granted is never serviced.

## Timing

- Grant in cycle T → memory controls asserted in cycles T+1 … T+`MEM_LATENCY`.
- `done` and `rdata` appear in cycle T+`MEM_LATENCY`+1, which is also an IDLE cycle.
- Maximum throughput: one access per `MEM_LATENCY`+1 cycles.
- Worst-case wait of a lane with `req` held: one full foreign access.
- `gnt` is combinational from `req`, state and `prio`. Every other output is registered.

## Configuration

- `DMEM_ARB_PERF_EN` defined adds two outputs:
  - `perf_accesses` [31:0]: counts grants.
  - `perf_conflicts` [31:0]: counts IDLE cycles with both `req` high.
- Both counters reset to 0 and wrap at 2^32.
- Undefined: the ports and counters do not exist. Arbitration behaviour is identical either way.

## Test plan

- **Single load, `MEM_LATENCY`=1.** Memory holds 0xDEAD_BEEF at 0x40; `l0_req`=1, `l0_we`=0, `l0_addr`=0x40 in cycle 0.
  - Required: `l0_gnt`=1 in cycle 0.
  - Required: `control_memread`=1 and `mem_address`=0x40 in cycle 1.
  - Required: `l0_done`=1 and `l0_rdata`=0xDEAD_BEEF in cycle 2.
- **Simultaneous requests.** Lane 0 stores 0x11 at 0x8 while lane 1 loads 0x8.
  - Required: lane 0 is granted in cycle 0 and `l0_done` pulses in cycle 2.
  - Required: lane 1 is granted in cycle 2 and `l1_done` pulses in cycle 4 with `l1_rdata`=0x11.
- **Round-robin.** Both `req` held high for 8 cycles.
  - Required: grants alternate 0,1,0,1 in cycles 0, 2, 4, 6.
- **`MEM_LATENCY`=3 store.** Lane 1 stores 0x55 at 0x100.
  - Required: `control_memwrite`=1 for cycles 1–3.
  - Required: `l1_done` in cycle 4 with `l1_rdata`=0.
- **Async reset during ACCESS (`MEM_LATENCY`=3).** Assert `RESET` low mid-cycle 2.
  - Required: `control_memread` and `control_memwrite` go to 0 at once, `busy`=0, and no `done` pulse follows.
- **`DMEM_ARB_PERF_EN` defined.** Run the round-robin scenario.
  - Required: `perf_accesses`=4 and `perf_conflicts`=4 afterwards.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-lane arbiter sharing a single-port data memory between the dual-issue MEM-stage lanes.
// Define DMEM_ARB_PERF_EN to add the perf_accesses / perf_conflicts counters.
module dmem_arbiter #(
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        l0_req,
    input  logic        l0_we,
    input  logic [63:0] l0_addr,
    input  logic [63:0] l0_wdata,
    input  logic        l1_req,
    input  logic        l1_we,
    input  logic [63:0] l1_addr,
    input  logic [63:0] l1_wdata,
    output logic        l0_gnt,
    output logic        l1_gnt,
    output logic        l0_done,
    output logic        l1_done,
    output logic [63:0] l0_rdata,
    output logic [63:0] l1_rdata,
    output logic        busy,
    output logic [63:0] mem_address,
    output logic [63:0] mem_data_in,
    output logic        control_memwrite,
    output logic        control_memread,
    input  logic [63:0] mem_data_out
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [31:0] perf_accesses,
    output logic [31:0] perf_conflicts
`endif
);

    localparam int unsigned CntW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CntW-1:0] CntInit = CntW'(MEM_LATENCY - 1);

    typedef enum logic {
        StIdle,
        StAccess
    } state_e;

    state_e          state_q, state_d;
    logic            prio_q, prio_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            lane_q, lane_d;
    logic            we_q, we_d;
    logic [63:0]     addr_q, addr_d;
    logic [63:0]     wdata_q, wdata_d;
    logic            memread_q, memread_d;
    logic            memwrite_q, memwrite_d;
    logic            done0_q, done0_d;
    logic            done1_q, done1_d;
    logic [63:0]     rdata0_q, rdata0_d;
    logic [63:0]     rdata1_q, rdata1_d;

    logic idle;
    logic gnt0;
    logic gnt1;

    // prio names the lane that wins when both request in the same IDLE cycle.
    always_comb begin
        idle = (state_q == StIdle);
        gnt0 = idle & l0_req & (~l1_req | ~prio_q);
        gnt1 = idle & l1_req & (~l0_req | prio_q);
    end

    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        cnt_d      = cnt_q;
        lane_d     = lane_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        memread_d  = memread_q;
        memwrite_d = memwrite_q;
        done0_d    = 1'b0;
        done1_d    = 1'b0;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;

        unique case (state_q)
            StIdle: begin
                if (gnt0 | gnt1) begin
                    lane_d     = gnt1;
                    we_d       = gnt1 ? l1_we : l0_we;
                    addr_d     = gnt1 ? l1_addr : l0_addr;
                    wdata_d    = gnt1 ? l1_wdata : l0_wdata;
                    cnt_d      = CntInit;
                    prio_d     = ~gnt1;
                    memread_d  = gnt1 ? ~l1_we : ~l0_we;
                    memwrite_d = gnt1 ? l1_we : l0_we;
                    state_d    = StAccess;
                end
            end
            StAccess: begin
                if (cnt_q == '0) begin
                    state_d    = StIdle;
                    memread_d  = 1'b0;
                    memwrite_d = 1'b0;
                    if (lane_q) begin
                        done1_d  = 1'b1;
                        rdata1_d = we_q ? 64'd0 : mem_data_out;
                    end else begin
                        done0_d  = 1'b1;
                        rdata0_d = we_q ? 64'd0 : mem_data_out;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= StIdle;
            prio_q     <= 1'b0;
            cnt_q      <= '0;
            lane_q     <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 64'd0;
            wdata_q    <= 64'd0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            rdata0_q   <= 64'd0;
            rdata1_q   <= 64'd0;
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            cnt_q      <= cnt_d;
            lane_q     <= lane_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            memread_q  <= memread_d;
            memwrite_q <= memwrite_d;
            done0_q    <= done0_d;
            done1_q    <= done1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
        end
    end

    assign l0_gnt           = gnt0;
    assign l1_gnt           = gnt1;
    assign l0_done          = done0_q;
    assign l1_done          = done1_q;
    assign l0_rdata         = rdata0_q;
    assign l1_rdata         = rdata1_q;
    assign busy             = (state_q == StAccess);
    assign mem_address      = addr_q;
    assign mem_data_in      = wdata_q;
    assign control_memread  = memread_q;
    assign control_memwrite = memwrite_q;

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] perf_acc_q, perf_acc_d;
    logic [31:0] perf_conf_q, perf_conf_d;

    always_comb begin
        perf_acc_d  = perf_acc_q;
        perf_conf_d = perf_conf_q;
        if (gnt0 | gnt1) begin
            perf_acc_d = perf_acc_q + 32'd1;
        end
        if (idle & l0_req & l1_req) begin
            perf_conf_d = perf_conf_q + 32'd1;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            perf_acc_q  <= 32'd0;
            perf_conf_q <= 32'd0;
        end else begin
            perf_acc_q  <= perf_acc_d;
            perf_conf_q <= perf_conf_d;
        end
    end

    assign perf_accesses  = perf_acc_q;
    assign perf_conflicts = perf_conf_q;
`endif

endmodule
